lora_frame_sequencer: RTL and testbench
=======================================

# lora_frame_sequencer

Frame-level controller that sequences the LoRa chirp modulator through one complete packet. It emits the programmable upchirp preamble, two sync-word upchirps, two downchirps, one quarter downchirp, then payload symbols pulled from a valid/ready stream. It advances one symbol per `symDone` pulse from the modulator. It sits between the packet/encoder front end and `loraModulator`, and drives that block's `symVal`, `symType` and run enable.

## Interface
- `SYM_W`, 12: symbol value width; matches the modulator symbol precision.
- `PRE_W`, 8: preamble length counter width.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: frame request pulse. Sampled only in IDLE.
- `preamble_len` in PRE_W: number of preamble upchirps. Latched at start.
- `sync_sym0`, `sync_sym1` in SYM_W: sync-word symbol values. Latched at start.
- `pay_valid` in 1, `pay_data` in SYM_W, `pay_last` in 1: payload symbol stream.
- `pay_ready` out 1: payload accept strobe.
- `sym_done` in 1: one-cycle pulse from the modulator, marking the end of the current symbol.
- `mod_run` out 1: modulator enable. Drive the modulator's active-low `rst` with it; 1 = run.
- `sym_val` out SYM_W: current symbol value.
- `sym_type` out 2: chirp type. 00 = upchirp, 01 = downchirp, 10 = quarter downchirp.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse on normal completion.
- `underrun` out 1: one-cycle pulse when a frame is aborted because payload was missing.
- `sym_count` out 16: symbols completed in the current frame.

## Operation
- States: IDLE, PRE, SYNC0, SYNC1, DOWN0, DOWN1, QDOWN, PAY.
- **Start.** In IDLE, `start=1` does the following:
  - latches the config;
  - sets `mod_run=1`, `busy=1`, `sym_count=0`;
  - if `preamble_len>0`: goes to PRE with `sym_val=0`, `sym_type=00`, preamble counter = `preamble_len-1`;
  - if `preamble_len==0`: goes directly to SYNC0.
- **Advance.** Each `sym_done` moves to the next symbol and registers the new `sym_val`/`sym_type` on that same edge. `sym_count` increments.
- **PRE.** Stay while the counter is non-zero (decrement on each `sym_done`), then go to SYNC0.
- **Sync symbols.** SYNC0 outputs `sync_sym0` with type 00. SYNC1 outputs `sync_sym1` with type 00.
- **Downchirps.** DOWN0 and DOWN1 output `sym_val=0`, type 01. QDOWN outputs `sym_val=0`, type 10.
- **Payload accept.** `pay_ready` is combinational: `pay_ready = sym_done & (state==QDOWN | (state==PAY & !cur_last))`.
  - An accepted word loads `sym_val=pay_data`, type 00, and `cur_last=pay_last`.
- **Underrun.** If `pay_ready=1` while `pay_valid=0`:
  - pulse `underrun`;
  - go to IDLE and drop `mod_run`/`busy`;
  - `sym_val`/`sym_type` go to 0.
- **Completion.** `sym_done` in PAY with `cur_last=1` does the following:
  - pulses `frame_done`;
  - goes to IDLE and drops `mod_run`/`busy`;
  - no payload is consumed.
- **Ignored inputs.**
  - `start` while busy is ignored.
  - `sym_done` in IDLE is ignored.
  - The config inputs may change freely after the start cycle.
- **Counters.** `sym_count` saturates at 0xFFFF and holds its final value in IDLE until the next start.

## Timing
- Reset values: state IDLE, and all outputs 0 (`mod_run`, `sym_val`, `sym_type`, `busy`, `frame_done`, `underrun`, `sym_count`). `pay_ready` is 0 in IDLE.
- Reset mid-frame: outputs return to reset values on the next edge. `pay_ready` is forced to 0 during reset, so no payload is consumed.
- Latency:
  - `start` to first symbol presented (`mod_run=1`): 1 cycle.
  - `sym_done` to next symbol presented: 1 cycle, registered.
- Frame length in symbols: `preamble_len + 5 + N_payload`.
- Back-to-back frames: `start` may arrive in the cycle after `frame_done`. `mod_run` is then low for exactly 1 cycle, which resets the modulator phase.

## Structure
- Shared defines header (alongside the existing LoRa TX defines): chirp-type codes (UP=00, DOWN=01, QDOWN=10) and the state encodings.
- One natural sub-module: `lora_sym_counter`, a loadable down-counter with a zero flag used for the preamble. The FSM and output registers stay in the top module.

## Test plan
- **Basic frame.** `preamble_len=8`, sync 0x012/0x034, 3 payload symbols (0x100, 0x200, 0x7FF with last), `sym_done` every 16 cycles.
  - Expect 8×(0,00), (0x012,00), (0x034,00), 2×(0,01), (0,10), then the 3 payload symbols.
  - `frame_done` after the 16th `sym_done`; final `sym_count=16`.
- **Zero preamble.** `preamble_len=0`: the first symbol is `sync_sym0`, and the frame has 5+N symbols.
- **Underrun.** `pay_valid` held low at the QDOWN `sym_done`:
  - `underrun` pulses and `pay_ready=1` that cycle;
  - `mod_run=0` the next cycle and state returns to IDLE.
- **Mid-frame reset.** `rst` asserted during SYNC1: all outputs are 0 on the next cycle, and a new `start` restarts from the preamble.
- **Back-to-back and ignored start.** `start` during busy has no effect. `start` in the cycle after `frame_done` gives exactly one `mod_run`-low cycle between the two frames.
- **Single-symbol payload.** Payload of one word with `pay_last=1`: `pay_ready` asserts exactly once per frame, and `frame_done` follows that symbol's `sym_done`.

Source files
------------

// File: rtl/lora_frame_sequencer_pkg.sv
// Shared LoRa TX frame definitions: chirp-type codes, sequencer state encoding
// and the saturating symbol-count helper.
package lora_frame_sequencer_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        CHIRP_UP    = 2'b00,
        CHIRP_DOWN  = 2'b01,
        CHIRP_QDOWN = 2'b10
    } chirp_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_SYNC0 = 3'd2,
        ST_SYNC1 = 3'd3,
        ST_DOWN0 = 3'd4,
        ST_DOWN1 = 3'd5,
        ST_QDOWN = 3'd6,
        ST_PAY   = 3'd7
    } seq_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/lora_frame_sequencer_if.sv
// Payload symbol stream from the packet/encoder front end into the frame sequencer.
interface lora_frame_sequencer_if #(
    parameter int SYM_W = 12
) ();
    logic             pay_valid;
    logic [SYM_W-1:0] pay_data;
    logic             pay_last;
    logic             pay_ready;

    modport master (output pay_valid, pay_data, pay_last, input pay_ready);
    modport slave  (input pay_valid, pay_data, pay_last, output pay_ready);
endinterface

// File: rtl/lora_sym_counter.sv
// Loadable down-counter with zero flag; counts remaining preamble upchirps.
module lora_sym_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] count_r;

    // Load takes priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != '0)) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == '0);
endmodule

// File: rtl/lora_frame_sequencer.sv
// Sequences the chirp modulator through preamble, sync, downchirps and payload
// of one LoRa packet, advancing one symbol per sym_done pulse.
module lora_frame_sequencer
    import lora_frame_sequencer_pkg::*;
#(
    parameter int SYM_W = 12,
    parameter int PRE_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PRE_W-1:0]     preamble_len,
    input  logic [SYM_W-1:0]     sync_sym0,
    input  logic [SYM_W-1:0]     sync_sym1,
    lora_frame_sequencer_if.slave pay,
    input  logic                 sym_done,
    output logic                 mod_run,
    output logic [SYM_W-1:0]     sym_val,
    output logic [1:0]           sym_type,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 underrun,
    output logic [CNT_W-1:0]     sym_count
);
    seq_state_t       state_r;
    logic [SYM_W-1:0] sync0_r;
    logic [SYM_W-1:0] sync1_r;
    logic             cur_last_r;
    logic             mod_run_r;
    logic [SYM_W-1:0] sym_val_r;
    chirp_t           sym_type_r;
    logic             busy_r;
    logic             frame_done_r;
    logic             underrun_r;
    logic [CNT_W-1:0] sym_count_r;
    logic             pay_ready_s;
    logic             cnt_load_s;
    logic             cnt_dec_s;
    logic             cnt_zero_s;

    // Held low through reset so a sym_done arriving then never consumes a word.
    assign pay_ready_s = !rst && sym_done &&
                         ((state_r == ST_QDOWN) || ((state_r == ST_PAY) && !cur_last_r));
    assign pay.pay_ready = pay_ready_s;

    assign cnt_load_s = (state_r == ST_IDLE) && start && (preamble_len != '0);
    assign cnt_dec_s  = (state_r == ST_PRE) && sym_done;

    lora_sym_counter #(.W(PRE_W)) u_pre_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (preamble_len - PRE_W'(1)),
        .dec      (cnt_dec_s),
        .zero     (cnt_zero_s)
    );

    // Frame FSM with registered symbol and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            sync0_r      <= '0;
            sync1_r      <= '0;
            cur_last_r   <= 1'b0;
            mod_run_r    <= 1'b0;
            sym_val_r    <= '0;
            sym_type_r   <= CHIRP_UP;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            underrun_r   <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            underrun_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        sync0_r    <= sync_sym0;
                        sync1_r    <= sync_sym1;
                        cur_last_r <= 1'b0;
                        mod_run_r  <= 1'b1;
                        busy_r     <= 1'b1;
                        sym_type_r <= CHIRP_UP;
                        if (preamble_len != '0) begin
                            state_r   <= ST_PRE;
                            sym_val_r <= '0;
                        end else begin
                            state_r   <= ST_SYNC0;
                            sym_val_r <= sync_sym0;
                        end
                    end
                end
                ST_PRE: begin
                    if (sym_done && cnt_zero_s) begin
                        state_r   <= ST_SYNC0;
                        sym_val_r <= sync0_r;
                    end
                end
                ST_SYNC0: begin
                    if (sym_done) begin
                        state_r   <= ST_SYNC1;
                        sym_val_r <= sync1_r;
                    end
                end
                ST_SYNC1: begin
                    if (sym_done) begin
                        state_r    <= ST_DOWN0;
                        sym_val_r  <= '0;
                        sym_type_r <= CHIRP_DOWN;
                    end
                end
                ST_DOWN0: begin
                    if (sym_done) begin
                        state_r <= ST_DOWN1;
                    end
                end
                ST_DOWN1: begin
                    if (sym_done) begin
                        state_r    <= ST_QDOWN;
                        sym_type_r <= CHIRP_QDOWN;
                    end
                end
                ST_QDOWN, ST_PAY: begin
                    if (sym_done) begin
                        if ((state_r == ST_PAY) && cur_last_r) begin
                            frame_done_r <= 1'b1;
                            state_r      <= ST_IDLE;
                            mod_run_r    <= 1'b0;
                            busy_r       <= 1'b0;
                            sym_val_r    <= '0;
                            sym_type_r   <= CHIRP_UP;
                        end else if (pay.pay_valid) begin
                            state_r    <= ST_PAY;
                            sym_val_r  <= pay.pay_data;
                            sym_type_r <= CHIRP_UP;
                            cur_last_r <= pay.pay_last;
                        end else begin
                            underrun_r <= 1'b1;
                            state_r    <= ST_IDLE;
                            mod_run_r  <= 1'b0;
                            busy_r     <= 1'b0;
                            sym_val_r  <= '0;
                            sym_type_r <= CHIRP_UP;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    mod_run_r  <= 1'b0;
                    busy_r     <= 1'b0;
                    sym_val_r  <= '0;
                    sym_type_r <= CHIRP_UP;
                end
            endcase
        end
    end

    // Symbols completed this frame: cleared at start, held through IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_count_r <= '0;
        end else if ((state_r == ST_IDLE) && start) begin
            sym_count_r <= '0;
        end else if ((state_r != ST_IDLE) && sym_done) begin
            sym_count_r <= sat_inc(sym_count_r);
        end else begin
            sym_count_r <= sym_count_r;
        end
    end

    assign mod_run    = mod_run_r;
    assign sym_val    = sym_val_r;
    assign sym_type   = sym_type_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign underrun   = underrun_r;
    assign sym_count  = sym_count_r;
endmodule

// File: tb/tb_lora_frame_sequencer.sv
// Randomized scoreboard bench for lora_frame_sequencer: the driver pushes the
// expected symbol list and per-sym_done outcomes; a negedge monitor pops and compares.
module tb_lora_frame_sequencer;
    import lora_frame_sequencer_pkg::*;

    localparam int SYM_W = 12;
    localparam int PRE_W = 8;

    typedef struct packed {
        logic [1:0]       typ;
        logic [SYM_W-1:0] val;
    } sym_t;

    // outcome: 0 = next symbol presented, 1 = frame_done, 2 = underrun
    typedef struct {
        bit ready;
        int outcome;
        int cnt;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             sym_done = 1'b0;
    logic [PRE_W-1:0] preamble_len = '0;
    logic [SYM_W-1:0] sync_sym0 = '0;
    logic [SYM_W-1:0] sync_sym1 = '0;
    logic             mod_run, busy, frame_done, underrun;
    logic [SYM_W-1:0] sym_val;
    logic [1:0]       sym_type;
    logic [15:0]      sym_count;

    lora_frame_sequencer_if #(.SYM_W(SYM_W)) pay ();

    lora_frame_sequencer #(.SYM_W(SYM_W), .PRE_W(PRE_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .preamble_len (preamble_len),
        .sync_sym0    (sync_sym0),
        .sync_sym1    (sync_sym1),
        .pay          (pay),
        .sym_done     (sym_done),
        .mod_run      (mod_run),
        .sym_val      (sym_val),
        .sym_type     (sym_type),
        .busy         (busy),
        .frame_done   (frame_done),
        .underrun     (underrun),
        .sym_count    (sym_count)
    );

    always #5 clk = ~clk;

    sym_t             exp_syms[$];
    rec_t             exp_recs[$];
    logic [SYM_W-1:0] pw[$];
    int               n_checks = 0;
    int               n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic sym_t mk(input logic [SYM_W-1:0] v, input logic [1:0] t);
        sym_t s;
        s.typ = t;
        s.val = v;
        return s;
    endfunction

    // ---------------- monitor ----------------
    bit   in_frame_m = 1'b0;
    bit   p_rst = 1'b0, p_start = 1'b0, p_done = 1'b0;
    rec_t p_rec;
    sym_t cur;
    int   last_cnt = 0;

    task automatic pop_sym(output sym_t s);
        chk("sym_available", 32'(exp_syms.size() != 0), 32'd1);
        if (exp_syms.size() != 0) s = exp_syms.pop_front();
        else s = mk('0, 2'b00);
    endtask

    always @(negedge clk) begin
        if (p_rst) begin
            chk("rst_ctrl", {mod_run, busy, frame_done, underrun, sym_type}, 32'd0);
            chk("rst_sym_val", 32'(sym_val), 32'd0);
            chk("rst_count", 32'(sym_count), 32'd0);
            chk("rst_queues_drained", 32'(exp_syms.size() + exp_recs.size()), 32'd0);
            exp_syms.delete();
            exp_recs.delete();
            in_frame_m = 1'b0;
            last_cnt = 0;
        end else if (p_start) begin
            pop_sym(cur);
            chk("start_sym", 32'({sym_type, sym_val}), 32'(cur));
            chk("start_ctrl", {mod_run, busy, frame_done, underrun}, 32'b1100);
            chk("start_count", 32'(sym_count), 32'd0);
            in_frame_m = 1'b1;
        end else if (p_done) begin
            case (p_rec.outcome)
                0: begin
                    pop_sym(cur);
                    chk("adv_sym", 32'({sym_type, sym_val}), 32'(cur));
                    chk("adv_ctrl", {mod_run, busy, frame_done, underrun}, 32'b1100);
                end
                1: begin
                    chk("done_ctrl", {mod_run, busy, frame_done, underrun}, 32'b0010);
                    in_frame_m = 1'b0;
                    last_cnt = p_rec.cnt;
                end
                default: begin
                    chk("underrun_ctrl", {mod_run, busy, frame_done, underrun}, 32'b0001);
                    chk("underrun_sym", 32'({sym_type, sym_val}), 32'd0);
                    in_frame_m = 1'b0;
                    last_cnt = p_rec.cnt;
                end
            endcase
            chk("sym_count", 32'(sym_count), 32'(p_rec.cnt));
        end else if (in_frame_m) begin
            chk("hold_ctrl", {mod_run, busy, frame_done, underrun}, 32'b1100);
            chk("hold_sym", 32'({sym_type, sym_val}), 32'(cur));
        end else begin
            chk("idle_ctrl", {mod_run, busy, frame_done, underrun}, 32'b0000);
            chk("idle_count", 32'(sym_count), 32'(last_cnt));
        end

        p_rst = rst;
        p_start = 1'b0;
        p_done = 1'b0;
        if (rst) begin
            chk("rst_pay_ready", 32'(pay.pay_ready), 32'd0);
        end else if (start && !in_frame_m) begin
            p_start = 1'b1;
            chk("start_pay_ready", 32'(pay.pay_ready), 32'd0);
        end else if (sym_done && in_frame_m) begin
            chk("rec_available", 32'(exp_recs.size() != 0), 32'd1);
            if (exp_recs.size() != 0) begin
                p_rec = exp_recs.pop_front();
                p_done = 1'b1;
                chk("pay_ready", 32'(pay.pay_ready), 32'(p_rec.ready));
            end
        end else begin
            chk("pay_ready_low", 32'(pay.pay_ready), 32'd0);
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_pay();
        pay.pay_valid = 1'($urandom);
        pay.pay_data  = SYM_W'($urandom);
        pay.pay_last  = 1'($urandom);
    endtask

    // Runs one frame with payload pw. under_u >= 0: word under_u is missing.
    // rst_k >= 0: reset asserted instead of the rst_k-th sym_done.
    task automatic run_frame(input int pre, input logic [SYM_W-1:0] s0, input logic [SYM_W-1:0] s1,
                             input int under_u, input int rst_k, input int gmin, input int gmax,
                             input bit b2b, input int ign_pct);
        sym_t frm[$];
        int   n, last_k, stop_k, gap, w;
        n = pw.size();
        for (int i = 0; i < pre; i++) frm.push_back(mk('0, CHIRP_UP));
        frm.push_back(mk(s0, CHIRP_UP));
        frm.push_back(mk(s1, CHIRP_UP));
        frm.push_back(mk('0, CHIRP_DOWN));
        frm.push_back(mk('0, CHIRP_DOWN));
        frm.push_back(mk('0, CHIRP_QDOWN));
        for (int i = 0; i < n; i++) frm.push_back(mk(pw[i], CHIRP_UP));
        last_k = (under_u >= 0) ? pre + 4 + under_u : frm.size() - 1;
        stop_k = (rst_k >= 0) ? rst_k : last_k + 1;
        exp_syms.push_back(frm[0]);
        for (int k = 0; k < stop_k; k++) begin
            rec_t r;
            r.cnt = k + 1;
            if (k < last_k) begin
                r.ready = (k + 1 >= pre + 5);
                r.outcome = 0;
                exp_syms.push_back(frm[k + 1]);
            end else begin
                r.ready = (under_u >= 0);
                r.outcome = (under_u >= 0) ? 2 : 1;
            end
            exp_recs.push_back(r);
        end

        sym_done = 1'b0;
        start = 1'b1;
        preamble_len = PRE_W'(pre);
        sync_sym0 = s0;
        sync_sym1 = s1;
        rand_pay();
        step();
        start = 1'b0;
        preamble_len = PRE_W'($urandom);
        sync_sym0 = SYM_W'($urandom);
        sync_sym1 = SYM_W'($urandom);
        for (int k = 0; k < stop_k; k++) begin
            gap = int'($urandom_range(gmax, gmin));
            for (int g = 0; g < gap; g++) begin
                sym_done = 1'b0;
                start = (int'($urandom_range(99, 0)) < ign_pct);
                rand_pay();
                step();
            end
            start = 1'b0;
            sym_done = 1'b1;
            w = k + 1 - (pre + 5);
            rand_pay();
            if (w >= 0 && w < n) begin
                pay.pay_valid = (w != under_u);
                if (w != under_u) pay.pay_data = pw[w];
                pay.pay_last = (w == n - 1);
            end
            step();
        end
        if (rst_k >= 0) begin
            sym_done = 1'b1;
            rst = 1'b1;
            step();
            rst = 1'b0;
        end
        sym_done = 1'b0;
        if (!b2b) begin
            for (int i = 0; i < 3; i++) begin
                sym_done = 1'($urandom);
                rand_pay();
                step();
            end
            sym_done = 1'b0;
        end
    endtask

    task automatic rand_payload(input int n);
        pw.delete();
        for (int i = 0; i < n; i++) pw.push_back(SYM_W'($urandom));
    endtask

    initial begin
        int n, u, pre;
        pay.pay_valid = 1'b0;
        pay.pay_data  = '0;
        pay.pay_last  = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Basic frame, sym_done every 16 cycles
        pw = '{12'h100, 12'h200, 12'h7FF};
        run_frame(8, 12'h012, 12'h034, -1, -1, 15, 15, 1'b0, 0);
        // Zero preamble
        rand_payload(4);
        run_frame(0, SYM_W'($urandom), SYM_W'($urandom), -1, -1, 1, 3, 1'b0, 0);
        // Underrun at the QDOWN sym_done
        rand_payload(2);
        run_frame(4, SYM_W'($urandom), SYM_W'($urandom), 0, -1, 1, 3, 1'b0, 0);
        // Reset while SYNC1 is presented, then restart from preamble
        rand_payload(2);
        run_frame(3, SYM_W'($urandom), SYM_W'($urandom), -1, 4, 1, 3, 1'b0, 0);
        rand_payload(2);
        run_frame(5, SYM_W'($urandom), SYM_W'($urandom), -1, -1, 1, 3, 1'b0, 0);
        // Back-to-back frames with ignored starts
        rand_payload(3);
        run_frame(2, SYM_W'($urandom), SYM_W'($urandom), -1, -1, 1, 4, 1'b1, 40);
        rand_payload(2);
        run_frame(3, SYM_W'($urandom), SYM_W'($urandom), -1, -1, 1, 4, 1'b0, 40);
        // Single-symbol payload
        rand_payload(1);
        run_frame(6, SYM_W'($urandom), SYM_W'($urandom), -1, -1, 0, 2, 1'b0, 0);

        for (int f = 0; f < 25; f++) begin
            n = int'($urandom_range(6, 1));
            u = ($urandom_range(4, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
            pre = ($urandom_range(9, 0) == 0) ? int'($urandom_range(255, 200)) : int'($urandom_range(12, 0));
            rand_payload(n);
            run_frame(pre, SYM_W'($urandom), SYM_W'($urandom), u, -1, 0, 3,
                      1'($urandom), 20);
        end

        repeat (4) step();
        chk("queues_drained", 32'(exp_syms.size() + exp_recs.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", n_checks);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "time limit");
    end
endmodule
